// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word and register-select widths.
package cpu_types_pkg;

    localparam int WORD_W = 32;
    localparam int REG_W  = 5;
    localparam int NREGS  = 1 << REG_W;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbits_t;

endpackage

// File: rtl/register_file_if.sv
// Register file bus: decode-side read selects, writeback-side write port.
interface register_file_if;
    import cpu_types_pkg::*;

    logic     WEN;
    regbits_t wsel;
    word_t    wdat;
    regbits_t rsel1;
    regbits_t rsel2;
    word_t    rdat1;
    word_t    rdat2;

    modport rf (
        input  WEN, wsel, wdat, rsel1, rsel2,
        output rdat1, rdat2
    );

    modport tb (
        output WEN, wsel, wdat, rsel1, rsel2,
        input  rdat1, rdat2
    );

endinterface

// File: rtl/register_file.sv
// 32x32 MIPS general-purpose register file: two combinational read ports,
// one synchronous write port, register 0 hardwired to zero.
module register_file
    import cpu_types_pkg::*;
(
    input logic           CLK,
    input logic           nRST,
    register_file_if.rf   rfif
);

    word_t [NREGS-1:0] register_file;

    // Writes to register 0 are dropped so entry 0 never leaves its reset value.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            register_file <= '0;
        end else if (rfif.WEN && (rfif.wsel != '0)) begin
            register_file[rfif.wsel] <= rfif.wdat;
        end
    end

    // No write-to-read bypass: forwarding is handled by the pipeline.
    always_comb begin
        rfif.rdat1 = '0;
        rfif.rdat2 = '0;
        if (rfif.rsel1 != '0) rfif.rdat1 = register_file[rfif.rsel1];
        if (rfif.rsel2 != '0) rfif.rdat2 = register_file[rfif.rsel2];
    end

endmodule

// File: tb/tb_register_file.sv
// Randomized self-checking bench for register_file against an array model.
module tb_register_file;
    import cpu_types_pkg::*;

    logic CLK;
    logic nRST;
    int   vectors;
    int   miscompares;
    word_t model [NREGS];

    register_file_if rfif ();

    register_file DUT (
        .CLK  (CLK),
        .nRST (nRST),
        .rfif (rfif.rf)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input word_t obs, input word_t exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NREGS; i++) model[i] = '0;
    endtask

    task automatic check_entries(input string tag);
        for (int i = 0; i < NREGS; i++)
            check($sformatf("%s[%0d]", tag, i), DUT.register_file[i], model[i]);
    endtask

    // Drive one cycle just after a rising edge, check reads before the next
    // edge, then commit the write to the model at that edge.
    task automatic apply(input logic wen, input regbits_t ws, input word_t wd,
                         input regbits_t r1, input regbits_t r2, input string tag);
        rfif.WEN   = wen;
        rfif.wsel  = ws;
        rfif.wdat  = wd;
        rfif.rsel1 = r1;
        rfif.rsel2 = r2;
        #2;
        check({tag, "_rdat1"}, rfif.rdat1, model[r1]);
        check({tag, "_rdat2"}, rfif.rdat2, model[r2]);
        @(posedge CLK);
        if (wen && ws != 0) model[ws] = wd;
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        nRST        = 1'b1;
        rfif.WEN    = 1'b0;
        rfif.wsel   = '0;
        rfif.wdat   = '0;
        rfif.rsel1  = '0;
        rfif.rsel2  = '0;

        // Reset pulse, one period low.
        @(posedge CLK); #1;
        nRST = 1'b0;
        #10;
        nRST = 1'b1;
        model_clear();
        check_entries("reset");

        // Post-reset read sweep.
        for (int i = 0; i < NREGS; i++)
            apply(1'b0, '0, '0, regbits_t'(i), regbits_t'(i), "post_reset_rd");

        // Write sweep: register i <- i; register 0 must stay zero.
        for (int i = 0; i < NREGS; i++)
            apply(1'b1, regbits_t'(i), word_t'(i), '0, '0, "wr_sweep");
        check_entries("after_sweep");
        check("sweep_r5_const", DUT.register_file[5], 32'd5);
        check("sweep_r0_const", DUT.register_file[0], 32'd0);

        // Dual reads after sweep.
        rfif.WEN = 1'b0; rfif.rsel1 = 5'd5; rfif.rsel2 = 5'd31; #1;
        check("dual_rd1_5", rfif.rdat1, 32'd5);
        check("dual_rd2_31", rfif.rdat2, 32'd31);
        rfif.rsel1 = 5'd0; rfif.rsel2 = 5'd0; #1;
        check("dual_rd1_0", rfif.rdat1, 32'd0);
        check("dual_rd2_0", rfif.rdat2, 32'd0);
        @(posedge CLK); #1;

        // Write disabled: register 3 keeps its value.
        apply(1'b0, 5'd3, 32'd4721, 5'd3, 5'd3, "wen_low");
        check("wen_low_r3", DUT.register_file[3], 32'd3);

        // Same-cycle read/write of register 3: old value until the edge.
        rfif.WEN = 1'b1; rfif.wsel = 5'd3; rfif.wdat = 32'd25119;
        rfif.rsel1 = 5'd3; rfif.rsel2 = 5'd3;
        #2;
        check("rw_before_edge", rfif.rdat1, 32'd3);
        @(posedge CLK); #1;
        check("rw_after_edge", rfif.rdat1, 32'd25119);
        check("rw_after_edge2", rfif.rdat2, 32'd25119);
        model[3] = 32'd25119;

        // Randomized traffic, biased toward writes.
        for (int n = 0; n < 400; n++) begin
            apply(($urandom_range(0, 3) != 0), regbits_t'($urandom_range(0, NREGS - 1)),
                  word_t'($urandom), regbits_t'($urandom_range(0, NREGS - 1)),
                  regbits_t'($urandom_range(0, NREGS - 1)), "rand");
        end
        check_entries("after_rand");

        // Async reset mid-write: entries clear without a clock edge.
        rfif.WEN = 1'b1; rfif.wsel = 5'd7; rfif.wdat = 32'hDEAD_BEEF;
        rfif.rsel1 = 5'd7; rfif.rsel2 = 5'd31;
        #2;
        nRST = 1'b0;
        #1;
        model_clear();
        check_entries("async_rst");
        check("async_rst_rdat1", rfif.rdat1, 32'd0);
        check("async_rst_rdat2", rfif.rdat2, 32'd0);
        @(posedge CLK); #1;
        check("rst_dominates_wr", DUT.register_file[7], 32'd0);
        check("rst_hold_rdat1", rfif.rdat1, 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK); #1;
        model[7] = 32'hDEAD_BEEF;
        check("wr_after_rst", rfif.rdat1, 32'hDEAD_BEEF);

        // A little more random traffic after recovery.
        for (int n = 0; n < 100; n++) begin
            apply(($urandom_range(0, 1) != 0), regbits_t'($urandom_range(0, NREGS - 1)),
                  word_t'($urandom), regbits_t'($urandom_range(0, NREGS - 1)),
                  regbits_t'($urandom_range(0, NREGS - 1)), "rand2");
        end
        check_entries("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
